// File: rtl/seq_shift_unit.sv
// Multi-cycle shift sequencer: captures an operand, applies one single-bit
// pass/LSL/LSR/ASR step per clock and presents a registered result with a done pulse.
module seq_shift_unit #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       shift,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_PASS = 2'b00,
      OP_LSL  = 2'b01,
      OP_LSR  = 2'b10,
      OP_ASR  = 2'b11
   } op_t;

   state_t           r_state;
   op_t              r_op;
   logic [WIDTH-1:0] r_data;
   logic [AMT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sout;
   logic [WIDTH-1:0] w_step;

   function automatic logic [WIDTH-1:0] step_fn(input op_t op, input logic [WIDTH-1:0] d);
      case (op)
         OP_LSL:  step_fn = {d[WIDTH-2:0], 1'b0};
         OP_LSR:  step_fn = {1'b0, d[WIDTH-1:1]};
         OP_ASR:  step_fn = {d[WIDTH-1], d[WIDTH-1:1]};
         default: step_fn = d;
      endcase
   endfunction

   assign w_step = step_fn(r_op, r_data);

   // NOTE: every register here uses <= so all updates in an edge see pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_op    <= OP_PASS;
         r_data  <= '0;
         r_cnt   <= '0;
         r_sout  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_data <= in;
                  r_op   <= op_t'(shift);
                  r_cnt  <= amount;
                  // A zero count or pass op has nothing to iterate, so the result is the operand.
                  if (amount == '0 || shift == OP_PASS) begin
                     r_sout  <= in;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               r_data <= w_step;
               r_cnt  <= r_cnt - AMT_W'(1);
               if (r_cnt == AMT_W'(1)) begin
                  r_sout  <= w_step;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state == ST_SHIFT);
   assign done = (r_state == ST_DONE);
   assign sout = r_sout;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed vector table, random requests
// against a shift-operator reference model, and reset/ignored-start corner sequences.
module tb_seq_shift_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] t_in;
   logic [1:0]  t_shift;
   logic [3:0]  t_amount;
   logic        busy;
   logic        done;
   logic [15:0] sout;

   int errors = 0;
   int checks = 0;

   seq_shift_unit #(.WIDTH(16), .AMT_W(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .in     (t_in),
      .shift  (t_shift),
      .amount (t_amount),
      .busy   (busy),
      .done   (done),
      .sout   (sout)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [1:0]  op;
      logic [3:0]  amt;
      logic [15:0] exp;
      int unsigned junk;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the whole shift in one arithmetic operation.
   function automatic logic [15:0] model(input logic [15:0] a, input logic [1:0] op, input logic [3:0] amt);
      case (op)
         2'b01:   model = a << amt;
         2'b10:   model = a >> amt;
         2'b11:   model = 16'($signed(a) >>> amt);
         default: model = a;
      endcase
   endfunction

   // Issue one request and observe it at negedges; junk bit n asserts a stray start with in=FFFF at negedge n.
   task automatic run_op(input string name, input logic [15:0] a, input logic [1:0] op,
                         input logic [3:0] amt, input logic [15:0] exp, input int unsigned junk);
      int exp_lat, exp_busy, done_cyc, busy_cnt, pulses;
      exp_lat  = (amt == 0 || op == 2'b00) ? 1 : int'(amt) + 1;
      exp_busy = (amt == 0 || op == 2'b00) ? 0 : int'(amt);
      done_cyc = -1;
      busy_cnt = 0;
      pulses   = 0;
      @(negedge clk);
      start = 1'b1; t_in = a; t_shift = op; t_amount = amt;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         start = junk[cyc];
         if (junk[cyc]) t_in = 16'hFFFF;
         if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
      end
      start = 1'b0;
      check({name, " latency"}, done_cyc, exp_lat);
      check({name, " busy_cycles"}, busy_cnt, exp_busy);
      check({name, " done_pulses"}, pulses, 1);
      check({name, " sout"}, sout, exp);
   endtask

   vec_t vecs[$];

   initial begin
      int n_done, n_busy;
      logic [15:0] ra;
      logic [1:0]  rop;
      logic [3:0]  ramt;

      vecs.push_back('{"lsl3",      16'h0001, 2'b01, 4'd3,  16'h0008, 0});
      vecs.push_back('{"asr15",     16'h8000, 2'b11, 4'd15, 16'hFFFF, 0});
      vecs.push_back('{"asr4",      16'h7FF0, 2'b11, 4'd4,  16'h07FF, 0});
      vecs.push_back('{"lsr4",      16'hF000, 2'b10, 4'd4,  16'h0F00, 0});
      vecs.push_back('{"lsl0",      16'h1234, 2'b01, 4'd0,  16'h1234, 0});
      vecs.push_back('{"pass9",     16'hABCD, 2'b00, 4'd9,  16'hABCD, 0});
      vecs.push_back('{"junkstart", 16'h0003, 2'b01, 4'd5,  16'h0060, 32'h24});
      vecs.push_back('{"lsr15",     16'h8000, 2'b10, 4'd15, 16'h0001, 0});
      vecs.push_back('{"lsl15",     16'h0001, 2'b01, 4'd15, 16'h8000, 0});
      vecs.push_back('{"asr15pos",  16'h7FFF, 2'b11, 4'd15, 16'h0000, 0});
      vecs.push_back('{"lsr1",      16'h0001, 2'b10, 4'd1,  16'h0000, 0});

      reset = 1'b1; start = 1'b0; t_in = '0; t_shift = '0; t_amount = '0;
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sout", sout, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].a, vecs[i].op, vecs[i].amt, vecs[i].exp, vecs[i].junk);

      for (int i = 0; i < 30; i++) begin
         ra   = 16'($urandom);
         rop  = 2'($urandom_range(0, 3));
         ramt = 4'($urandom_range(0, 15));
         run_op($sformatf("rand%0d", i), ra, rop, ramt, model(ra, rop, ramt), 0);
      end

      // Asynchronous reset after three steps of an 8-step request.
      run_op("pre_reset", 16'hABCD, 2'b00, 4'd2, 16'hABCD, 0);
      @(negedge clk);
      start = 1'b1; t_in = 16'h0001; t_shift = 2'b01; t_amount = 4'd8;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("midreset busy", busy, 0);
      check("midreset done", done, 0);
      check("midreset sout", sout, 0);
      @(negedge clk);
      reset = 1'b0;
      n_done = 0; n_busy = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      check("midreset no_done", n_done, 0);
      check("midreset no_busy", n_busy, 0);
      run_op("after_reset", 16'h0001, 2'b01, 4'd1, 16'h0002, 0);

      // Start coincident with reset is lost.
      @(negedge clk);
      start = 1'b1; reset = 1'b1; t_in = 16'h00F0; t_shift = 2'b01; t_amount = 4'd2;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      n_done = 0; n_busy = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) n_done++;
         if (busy) n_busy++;
      end
      check("start_with_reset no_done", n_done, 0);
      check("start_with_reset no_busy", n_busy, 0);
      check("start_with_reset sout", sout, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
